// File: rtl/udma_filter_rx_datastore.sv
// Stores the filter output stream to L2 through a uDMA RX channel, generating linear or 2D addresses.
// Optional 2D (row/stride) addressing is built only when UDMA_FILTER_DATASTORE_2D_EN is defined.
module udma_filter_rx_datastore #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned L2_AWIDTH_NOAL = 15,
   parameter int unsigned TRANS_SIZE     = 16
) (
   input  logic                      clk_i,
   input  logic                      resetn_i,
   input  logic                      cmd_start_i,
   output logic                      cmd_done_o,
   output logic                      err_o,
   input  logic [L2_AWIDTH_NOAL-1:0] cfg_start_addr_i,
   input  logic [1:0]                cfg_datasize_i,
   input  logic                      cfg_mode_i,
   input  logic [TRANS_SIZE-1:0]     cfg_len0_i,
   input  logic [TRANS_SIZE-1:0]     cfg_len1_i,
   input  logic [TRANS_SIZE-1:0]     cfg_stride_i,
   input  logic [DATA_WIDTH-1:0]     stream_data_i,
   input  logic [1:0]                stream_datasize_i,
   input  logic                      stream_valid_i,
   output logic                      stream_ready_o,
   input  logic                      stream_sof_i,
   input  logic                      stream_eof_i,
   output logic                      rx_ch_valid_o,
   input  logic                      rx_ch_ready_i,
   output logic [L2_AWIDTH_NOAL-1:0] rx_ch_addr_o,
   output logic [1:0]                rx_ch_datasize_o,
   output logic [DATA_WIDTH-1:0]     rx_ch_data_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

   state_t                    r_state;
   logic [L2_AWIDTH_NOAL-1:0] r_ptr;
   logic [TRANS_SIZE-1:0]     r_len0;
   logic [TRANS_SIZE-1:0]     r_cnt_w;
   logic                      r_first;
   logic [L2_AWIDTH_NOAL-1:0] inc;
   logic                      row_end;
   logic                      last_beat;
   logic                      accept;
   logic                      rx_hs;
   logic                      unused_in;

`ifdef UDMA_FILTER_DATASTORE_2D_EN
   logic                      r_mode;
   logic [TRANS_SIZE-1:0]     r_len1;
   logic [L2_AWIDTH_NOAL-1:0] r_stride;
   logic [L2_AWIDTH_NOAL-1:0] r_rowstart;
   logic [TRANS_SIZE-1:0]     r_cnt_l;

   assign unused_in = ^{stream_datasize_i};
`else
   assign unused_in = ^{stream_datasize_i, cfg_mode_i, cfg_len1_i, cfg_stride_i};
`endif

   // Single-entry output register: take a new beat when empty or draining this cycle
   assign rx_hs          = rx_ch_valid_o && rx_ch_ready_i;
   assign stream_ready_o = (r_state == ST_RUN) && (!rx_ch_valid_o || rx_ch_ready_i);
   assign accept         = stream_valid_i && stream_ready_o;
   assign cmd_done_o     = (r_state == ST_FLUSH) && rx_hs;

   always_comb begin
      inc = '0;
      case (rx_ch_datasize_o)
         2'd0:    inc = L2_AWIDTH_NOAL'(1);
         2'd1:    inc = L2_AWIDTH_NOAL'(2);
         2'd2:    inc = L2_AWIDTH_NOAL'(4);
         default: inc = '0;
      endcase
      row_end = (r_cnt_w == r_len0);
`ifdef UDMA_FILTER_DATASTORE_2D_EN
      last_beat = row_end && (!r_mode || (r_cnt_l == r_len1));
`else
      last_beat = row_end;
`endif
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_state          <= ST_IDLE;
         r_ptr            <= '0;
         r_len0           <= '0;
         r_cnt_w          <= '0;
         r_first          <= 1'b0;
         err_o            <= 1'b0;
         rx_ch_valid_o    <= 1'b0;
         rx_ch_addr_o     <= '0;
         rx_ch_datasize_o <= '0;
         rx_ch_data_o     <= '0;
`ifdef UDMA_FILTER_DATASTORE_2D_EN
         r_mode           <= 1'b0;
         r_len1           <= '0;
         r_stride         <= '0;
         r_rowstart       <= '0;
         r_cnt_l          <= '0;
`endif
      end else begin
         if (rx_hs) rx_ch_valid_o <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cmd_start_i) begin
                  r_state          <= ST_RUN;
                  r_ptr            <= cfg_start_addr_i;
                  r_len0           <= cfg_len0_i;
                  r_cnt_w          <= '0;
                  r_first          <= 1'b1;
                  err_o            <= 1'b0;
                  rx_ch_datasize_o <= cfg_datasize_i;
`ifdef UDMA_FILTER_DATASTORE_2D_EN
                  r_mode           <= cfg_mode_i;
                  r_len1           <= cfg_len1_i;
                  r_stride         <= L2_AWIDTH_NOAL'(cfg_stride_i);
                  r_rowstart       <= cfg_start_addr_i;
                  r_cnt_l          <= '0;
`endif
               end
            end
            ST_RUN: begin
               if (accept) begin
                  rx_ch_valid_o <= 1'b1;
                  rx_ch_data_o  <= stream_data_i;
                  rx_ch_addr_o  <= r_ptr;
                  r_first       <= 1'b0;
                  // Framing problems are only flagged; addressing stays length-driven
                  if ((stream_eof_i != last_beat) || (stream_sof_i && !r_first))
                     err_o <= 1'b1;
                  if (last_beat) begin
                     r_state <= ST_FLUSH;
                  end
`ifdef UDMA_FILTER_DATASTORE_2D_EN
                  else if (row_end) begin
                     r_rowstart <= r_rowstart + r_stride;
                     r_ptr      <= r_rowstart + r_stride;
                     r_cnt_w    <= '0;
                     r_cnt_l    <= r_cnt_l + TRANS_SIZE'(1);
                  end
`endif
                  else begin
                     r_ptr   <= r_ptr + inc;
                     r_cnt_w <= r_cnt_w + TRANS_SIZE'(1);
                  end
               end
            end
            ST_FLUSH: begin
               if (rx_hs) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udma_filter_rx_datastore.sv
// Directed bench for udma_filter_rx_datastore: linear/2D addressing, backpressure, wrap, framing, reset.
// The 2D vector runs when UDMA_FILTER_DATASTORE_2D_EN is defined, otherwise mode is checked as ignored.
module tb_udma_filter_rx_datastore;

   logic        clk_i = 1'b0;
   logic        resetn_i = 1'b0;
   logic        cmd_start_i = 1'b0;
   logic        cmd_done_o;
   logic        err_o;
   logic [14:0] cfg_start_addr_i = '0;
   logic [1:0]  cfg_datasize_i = '0;
   logic        cfg_mode_i = 1'b0;
   logic [15:0] cfg_len0_i = '0;
   logic [15:0] cfg_len1_i = '0;
   logic [15:0] cfg_stride_i = '0;
   logic [31:0] stream_data_i = '0;
   logic [1:0]  stream_datasize_i = '0;
   logic        stream_valid_i = 1'b0;
   logic        stream_ready_o;
   logic        stream_sof_i = 1'b0;
   logic        stream_eof_i = 1'b0;
   logic        rx_ch_valid_o;
   logic        rx_ch_ready_i = 1'b1;
   logic [14:0] rx_ch_addr_o;
   logic [1:0]  rx_ch_datasize_o;
   logic [31:0] rx_ch_data_o;

   int n_tot = 0;
   int n_bad = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   logic [14:0] q_addr[$];
   logic [31:0] q_data[$];
   int          q_cyc[$];

   udma_filter_rx_datastore #(.DATA_WIDTH(32), .L2_AWIDTH_NOAL(15), .TRANS_SIZE(16)) dut (
      .clk_i(clk_i), .resetn_i(resetn_i), .cmd_start_i(cmd_start_i), .cmd_done_o(cmd_done_o),
      .err_o(err_o), .cfg_start_addr_i(cfg_start_addr_i), .cfg_datasize_i(cfg_datasize_i),
      .cfg_mode_i(cfg_mode_i), .cfg_len0_i(cfg_len0_i), .cfg_len1_i(cfg_len1_i),
      .cfg_stride_i(cfg_stride_i), .stream_data_i(stream_data_i),
      .stream_datasize_i(stream_datasize_i), .stream_valid_i(stream_valid_i),
      .stream_ready_o(stream_ready_o), .stream_sof_i(stream_sof_i), .stream_eof_i(stream_eof_i),
      .rx_ch_valid_o(rx_ch_valid_o), .rx_ch_ready_i(rx_ch_ready_i), .rx_ch_addr_o(rx_ch_addr_o),
      .rx_ch_datasize_o(rx_ch_datasize_o), .rx_ch_data_o(rx_ch_data_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Record every completed channel write and every done pulse
   always @(negedge clk_i) begin
      if (rx_ch_valid_o && rx_ch_ready_i) begin
         q_addr.push_back(rx_ch_addr_o);
         q_data.push_back(rx_ch_data_o);
         q_cyc.push_back(cyc);
      end
      if (cmd_done_o) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot = n_tot + 1;
      if (got !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      q_addr.delete();
      q_data.delete();
      q_cyc.delete();
   endtask

   task automatic start(input logic [1:0] ds, input logic mode, input logic [14:0] addr,
                        input logic [15:0] l0, input logic [15:0] l1, input logic [15:0] stride);
      @(posedge clk_i); #1;
      cfg_datasize_i = ds; cfg_mode_i = mode; cfg_start_addr_i = addr;
      cfg_len0_i = l0; cfg_len1_i = l1; cfg_stride_i = stride;
      cmd_start_i = 1'b1;
      @(posedge clk_i); #1;
      cmd_start_i = 1'b0;
      chk("ready_after_start", 32'(stream_ready_o), 32'd1);
   endtask

   task automatic push(input logic [31:0] d, input logic sof, input logic eof);
      bit ok = 1'b0;
      stream_valid_i = 1'b1; stream_data_i = d; stream_sof_i = sof; stream_eof_i = eof;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_i);
         if (stream_ready_o) begin ok = 1'b1; break; end
      end
      if (!ok) chk("push_timeout", 32'd0, 32'd1);
      @(posedge clk_i); #1;
      stream_valid_i = 1'b0; stream_sof_i = 1'b0; stream_eof_i = 1'b0;
   endtask

   task automatic wait_done(input int target);
      bit ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (done_cnt >= target) begin ok = 1'b1; break; end
         @(posedge clk_i); #1;
      end
      if (!ok) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic chk_writes(input string tag, input int n, input logic [14:0] a0,
                             input logic [14:0] step);
      chk({tag, "_count"}, 32'(q_addr.size()), 32'(n));
      for (int i = 0; i < n && i < q_addr.size(); i++)
         chk({tag, "_addr"}, 32'(q_addr[i]), 32'(15'(a0 + 15'(i) * step)));
   endtask

   initial begin
      int d0;
      // Reset state
      #1;
      chk("rst_valid", 32'(rx_ch_valid_o), 0); chk("rst_addr", 32'(rx_ch_addr_o), 0);
      chk("rst_data", rx_ch_data_o, 0);        chk("rst_ds", 32'(rx_ch_datasize_o), 0);
      chk("rst_ready", 32'(stream_ready_o), 0); chk("rst_done", 32'(cmd_done_o), 0);
      chk("rst_err", 32'(err_o), 0);
      #22 resetn_i = 1'b1;

      // Linear word transfer, with a stray start mid-run that must be ignored
      clear_log(); d0 = done_cnt;
      @(negedge clk_i); chk("idle_ready", 32'(stream_ready_o), 0);
      start(2'd2, 1'b0, 15'h100, 16'd3, 16'd0, 16'd0);
      push(32'hA0, 1'b1, 1'b0);
      push(32'hA1, 1'b0, 1'b0);
      cmd_start_i = 1'b1; cfg_start_addr_i = 15'h999;
      push(32'hA2, 1'b0, 1'b0);
      cmd_start_i = 1'b0;
      push(32'hA3, 1'b0, 1'b1);
      wait_done(d0 + 1);
      chk_writes("lin", 4, 15'h100, 15'd4);
      if (q_addr.size() == 4) begin
         for (int i = 0; i < 4; i++) chk("lin_data", q_data[i], 32'hA0 + 32'(i));
         chk("lin_b2b", 32'(q_cyc[3] - q_cyc[0]), 32'd3);
         chk("lin_done_cyc", 32'(done_cyc), 32'(q_cyc[3]));
      end
      chk("lin_ds", 32'(rx_ch_datasize_o), 32'd2);
      chk("lin_err", 32'(err_o), 0);
      chk("lin_done_cnt", 32'(done_cnt - d0), 1);

`ifdef UDMA_FILTER_DATASTORE_2D_EN
      // 2D byte transfer: 2 samples per row, 3 rows, stride 0x10
      begin
         logic [14:0] exp2d[6];
         exp2d = '{15'h200, 15'h201, 15'h210, 15'h211, 15'h220, 15'h221};
         clear_log(); d0 = done_cnt;
         start(2'd0, 1'b1, 15'h200, 16'd1, 16'd2, 16'h10);
         for (int i = 0; i < 6; i++) push(32'hC0 + 32'(i), i == 0, i == 5);
         wait_done(d0 + 1);
         chk("2d_count", 32'(q_addr.size()), 6);
         for (int i = 0; i < 6 && i < q_addr.size(); i++) chk("2d_addr", 32'(q_addr[i]), 32'(exp2d[i]));
         chk("2d_err", 32'(err_o), 0);
      end
`else
      // Linear-only build: mode/len1/stride have no effect
      clear_log(); d0 = done_cnt;
      start(2'd0, 1'b1, 15'h200, 16'd1, 16'd2, 16'h10);
      push(32'hC0, 1'b1, 1'b0);
      push(32'hC1, 1'b0, 1'b1);
      wait_done(d0 + 1);
      chk_writes("lin_mode", 2, 15'h200, 15'd1);
      chk("lin_mode_err", 32'(err_o), 0);
`endif

      // Backpressure: channel stalls for 3 cycles while beat 2 sits in the output register
      clear_log(); d0 = done_cnt;
      start(2'd2, 1'b0, 15'h300, 16'd3, 16'd0, 16'd0);
      fork
         begin
            for (int i = 0; i < 4; i++) push(32'hB0 + 32'(i), i == 0, i == 3);
         end
         begin
            for (int i = 0; i < 50; i++) begin
               @(posedge clk_i); #1;
               if (q_addr.size() >= 1) break;
            end
            rx_ch_ready_i = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk_i);
               chk("bp_ready", 32'(stream_ready_o), 0);
               chk("bp_valid", 32'(rx_ch_valid_o), 1);
               chk("bp_addr", 32'(rx_ch_addr_o), 32'h304);
               chk("bp_data", rx_ch_data_o, 32'hB1);
            end
            @(posedge clk_i); #1;
            rx_ch_ready_i = 1'b1;
         end
      join
      wait_done(d0 + 1);
      chk_writes("bp", 4, 15'h300, 15'd4);
      for (int i = 0; i < 4 && i < q_data.size(); i++) chk("bp_order", q_data[i], 32'hB0 + 32'(i));

      // Address wrap at the top of the 15-bit space
      clear_log(); d0 = done_cnt;
      start(2'd1, 1'b0, 15'h7FFE, 16'd2, 16'd0, 16'd0);
      for (int i = 0; i < 3; i++) push(32'hD0 + 32'(i), i == 0, i == 2);
      wait_done(d0 + 1);
      chk_writes("wrap", 3, 15'h7FFE, 15'd2);
      chk("wrap_ds", 32'(rx_ch_datasize_o), 32'd1);

      // Early eof: error sticky from the next cycle, length still honoured
      clear_log(); d0 = done_cnt;
      start(2'd2, 1'b0, 15'h400, 16'd3, 16'd0, 16'd0);
      push(32'hE0, 1'b1, 1'b0);
      chk("frm_err_pre", 32'(err_o), 0);
      push(32'hE1, 1'b0, 1'b1);
      chk("frm_err_set", 32'(err_o), 1);
      push(32'hE2, 1'b0, 1'b0);
      push(32'hE3, 1'b0, 1'b0);
      wait_done(d0 + 1);
      chk_writes("frm", 4, 15'h400, 15'd4);
      chk("frm_err_hold", 32'(err_o), 1);
      // Next start clears the error; stray sof on beat 2 sets it again
      clear_log(); d0 = done_cnt;
      start(2'd2, 1'b0, 15'h480, 16'd1, 16'd0, 16'd0);
      chk("frm_err_clr", 32'(err_o), 0);
      push(32'hF0, 1'b1, 1'b0);
      chk("sof_err_pre", 32'(err_o), 0);
      push(32'hF1, 1'b1, 1'b1);
      chk("sof_err_set", 32'(err_o), 1);
      wait_done(d0 + 1);
      chk_writes("sof", 2, 15'h480, 15'd4);

      // Reset with a beat pending on the channel, then a single-beat transfer
      clear_log();
      start(2'd2, 1'b0, 15'h600, 16'd3, 16'd0, 16'd0);
      rx_ch_ready_i = 1'b0;
      push(32'h55, 1'b1, 1'b0);
      chk("prst_valid", 32'(rx_ch_valid_o), 1);
      #2 resetn_i = 1'b0;
      #1;
      chk("arst_valid", 32'(rx_ch_valid_o), 0); chk("arst_addr", 32'(rx_ch_addr_o), 0);
      chk("arst_data", rx_ch_data_o, 0);        chk("arst_ds", 32'(rx_ch_datasize_o), 0);
      chk("arst_ready", 32'(stream_ready_o), 0); chk("arst_err", 32'(err_o), 0);
      @(posedge clk_i); #1;
      resetn_i = 1'b1; rx_ch_ready_i = 1'b1;
      clear_log(); d0 = done_cnt;
      start(2'd2, 1'b0, 15'h700, 16'd0, 16'd0, 16'd0);
      push(32'h77, 1'b1, 1'b1);
      wait_done(d0 + 1);
      repeat (5) @(posedge clk_i);
      #1;
      chk_writes("post_rst", 1, 15'h700, 15'd4);
      if (q_data.size() == 1) chk("post_rst_data", q_data[0], 32'h77);
      chk("post_rst_done", 32'(done_cnt - d0), 1);
      chk("post_rst_err", 32'(err_o), 0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
